program_loader: RTL and testbench

- Instruction store plus serial program loader that feeds the CPU's fetch port.
- Responds to the CPU's pc with the instruction at that address.
- Fills its memory from a byte stream (valid/ready) and holds the CPU in reset until a complete program has been written.
- Sits beside cpu in Top: its instruction output drives the CPU's instruction input, and its holdCpu output drives the CPU's isReset input.

---
 rtl/loader_pkg.sv | 6 +
 rtl/instruction_ram.sv | 21 ++
 rtl/program_loader.sv | 96 +++++++++
 tb/tb_program_loader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader.
package loader_pkg;
  typedef enum logic [1:0] {HEADER_HI, HEADER_LO, DATA, RUN} state_e;
  localparam int HEADER_BYTES = 2;
  localparam int BYTE_WIDTH = 8;
endpackage

// File: rtl/instruction_ram.sv
// instruction_ram: single write port, read-first registered read port; contents survive reset.
module instruction_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk_i)
    rdata_q <= rst_ni ? mem_q[raddr_i] : '0;
  assign rdata_o = rdata_q;
endmodule

// File: rtl/program_loader.sv
// program_loader: instruction store filled from a header+data byte stream; holds the CPU until loaded.
module program_loader
  import loader_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         byteValid,
  input  logic [BYTE_WIDTH-1:0]        byteData,
  output logic                         byteReady,
  input  logic                         reload,
  input  logic [PC_WIDTH-1:0]          pc,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         holdCpu,
  output logic                         loadDone
);
  localparam int BYTES_PER_WORD = INSTRUCTION_WIDTH / BYTE_WIDTH;
  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  state_e state_q, state_d;
  logic [2*BYTE_WIDTH-1:0] last_q, last_d;
  logic [PC_WIDTH-1:0] waddr_q, waddr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [INSTRUCTION_WIDTH-1:0] word_q, word_d, word_nx;
  logic done_q, done_d;
  logic accept, word_end, last_word, we;
  assign byteReady = reset && !reload && state_q != RUN;
  assign accept = byteValid && byteReady;
  assign word_end = cnt_q == CW'(BYTES_PER_WORD - 1);
  assign last_word = waddr_q == PC_WIDTH'(last_q);
  assign word_nx = (word_q << BYTE_WIDTH) | INSTRUCTION_WIDTH'(byteData);
  assign we = accept && state_q == DATA && word_end;
  assign holdCpu = state_q != RUN;
  assign loadDone = done_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    waddr_d = waddr_q;
    cnt_d = cnt_q;
    word_d = word_q;
    done_d = 1'b0;
    if (reload) begin
      state_d = HEADER_HI;
      cnt_d = '0;
      word_d = '0;
    end else if (accept) begin
      case (state_q)
        HEADER_HI: begin
          last_d[2*BYTE_WIDTH-1:BYTE_WIDTH] = byteData;
          state_d = HEADER_LO;
        end
        HEADER_LO: begin
          last_d[BYTE_WIDTH-1:0] = byteData;
          waddr_d = '0;
          cnt_d = '0;
          state_d = DATA;
        end
        DATA: begin
          word_d = word_nx;
          cnt_d = word_end ? '0 : cnt_q + 1'b1;
          waddr_d = word_end && !last_word ? waddr_q + 1'b1 : waddr_q;
          state_d = word_end && last_word ? RUN : DATA;
          done_d = word_end && last_word;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= HEADER_HI;
      last_q <= '0;
      waddr_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      waddr_q <= waddr_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      done_q <= done_d;
    end
  end
  instruction_ram #(.AW(PC_WIDTH), .DW(INSTRUCTION_WIDTH)) u_ram (
    .clk_i   (clock),
    .rst_ni  (reset),
    .we_i    (we),
    .waddr_i (waddr_q),
    .wdata_i (word_nx),
    .raddr_i (pc),
    .rdata_o (instruction)
  );
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized directed bench against an array model of the instruction store.
module tb_program_loader;
  localparam int PW = 8;
  localparam int IW = 16;
  localparam int BPW = IW / 8;
  localparam int N = 2**PW;
  logic clock = 0, reset = 0, byteValid = 0, reload = 0;
  logic [7:0] byteData = 0;
  logic [PW-1:0] pc = 0;
  logic byteReady, holdCpu, loadDone;
  logic [IW-1:0] instruction;
  int compared = 0, mismatched = 0, done_cnt = 0, acc_cnt = 0;
  logic [IW-1:0] ref_mem [N];
  program_loader #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW)) dut (
    .clock(clock), .reset(reset), .byteValid(byteValid), .byteData(byteData),
    .byteReady(byteReady), .reload(reload), .pc(pc), .instruction(instruction),
    .holdCpu(holdCpu), .loadDone(loadDone)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (byteValid && byteReady) acc_cnt++;
    if (loadDone) done_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // mode 0: valid always high, 1: valid pattern 1,0,0,1, 2: random gaps
  task automatic send(input logic [7:0] b[$], input int mode, input bit track);
    int i = 0, k = 0;
    bit acc;
    while (i < b.size() && k < 8 * b.size() + 64) begin
      byteValid = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom_range(0, 1));
      byteData = b[i];
      if (track && i >= 2) pc = PW'((i - 2) / BPW);
      #1;
      acc = byteValid && byteReady;
      tick();
      if (acc && track && i >= 2 && (i - 2) % BPW == BPW - 1)
        chk("rdw_old", 32'(instruction), 32'(ref_mem[(i - 2) / BPW]));
      if (acc) i++;
      k++;
    end
    byteValid = 0;
    chk("send_complete", i, b.size());
  endtask
  task automatic load(input int last, input logic [IW-1:0] w[$], input int mode, input bit track);
    logic [7:0] b[$];
    int d0 = done_cnt;
    b.push_back(8'(last >> 8));
    b.push_back(8'(last));
    foreach (w[j]) for (int m = BPW - 1; m >= 0; m--) b.push_back(8'(w[j] >> (8 * m)));
    send(b, mode, track);
    chk("done_pulse", 32'(loadDone), 1);
    chk("hold_fall", 32'(holdCpu), 0);
    tick();
    chk("done_single", 32'(loadDone), 0);
    chk("ready_run", 32'(byteReady), 0);
    chk("done_count", done_cnt - d0, 1);
    foreach (w[j]) ref_mem[j] = w[j];
  endtask
  task automatic pulse_reload();
    reload = 1;
    tick();
    reload = 0;
    chk("reload_hold", 32'(holdCpu), 1);
  endtask
  task automatic peek(input int a, input string tag);
    pc = PW'(a);
    tick();
    chk(tag, 32'(instruction), 32'(ref_mem[a]));
  endtask
  initial begin
    logic [IW-1:0] w[$];
    logic [7:0] b[$];
    int a0, d0;
    repeat (3) tick();
    chk("rst_hold", 32'(holdCpu), 1);
    chk("rst_done", 32'(loadDone), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_ready", 32'(byteReady), 0);
    reset = 1;
    #1;
    chk("ready_after_rst", 32'(byteReady), 1);
    tick();
    // basic load
    w = '{16'h1234, 16'hABCD};
    load(1, w, 0, 0);
    peek(1, "basic_mem1");
    peek(0, "basic_mem0");
    // back-pressure in RUN
    a0 = acc_cnt;
    byteValid = 1;
    byteData = 8'h55;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 32'(byteReady), 0);
      tick();
    end
    byteValid = 0;
    chk("bp_accepts", acc_cnt - a0, 0);
    peek(0, "bp_mem0");
    peek(1, "bp_mem1");
    // gapped stream
    pulse_reload();
    a0 = acc_cnt;
    load(1, w, 1, 0);
    chk("gap_accepts", acc_cnt - a0, 6);
    peek(0, "gap_mem0");
    peek(1, "gap_mem1");
    // reload mid-load discards the partial word
    pulse_reload();
    d0 = done_cnt;
    b = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h22};
    send(b, 0, 0);
    chk("mid_hold", 32'(holdCpu), 1);
    byteValid = 1;
    byteData = 8'h99;
    reload = 1;
    #1;
    chk("reload_ready_low", 32'(byteReady), 0);
    tick();
    reload = 0;
    byteValid = 0;
    chk("reload_hold2", 32'(holdCpu), 1);
    chk("reload_no_done", done_cnt - d0, 0);
    w = '{16'h7788};
    load(0, w, 2, 0);
    peek(0, "reload_mem0");
    peek(1, "reload_mem1_kept");
    // full depth random load, random gaps
    pulse_reload();
    w = {};
    for (int a = 0; a < N; a++) w.push_back(IW'($urandom));
    load(N - 1, w, 2, 0);
    for (int a = 0; a < N; a++) peek(a, "rand_sweep");
    // full depth with read-during-write checking old data
    pulse_reload();
    w = {};
    for (int a = 0; a < N; a++) w.push_back(IW'(a * 16'h0101));
    load(N - 1, w, 0, 1);
    for (int a = 0; a < N; a++) peek(a, "addr_sweep");
    // reset mid-load keeps memory, restarts the header
    pulse_reload();
    b = '{8'h00, 8'h05, 8'hEE};
    send(b, 0, 0);
    reset = 0;
    tick();
    chk("midrst_hold", 32'(holdCpu), 1);
    chk("midrst_instr", 32'(instruction), 0);
    reset = 1;
    tick();
    w = '{16'hC0DE};
    load(0, w, 2, 0);
    peek(0, "midrst_mem0");
    peek(7, "midrst_mem7");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
